// File: rtl/hash_state_bank.sv
// Per-channel SHA-256 chaining-value store. Channels can be set to the IV, loaded,
// or feed-forward accumulated through one shared word-wide adder.
module hash_state_bank #(
    parameter int WORD_W   = 32,
    parameter int WORDS    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter logic [WORDS*WORD_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    }
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [1:0]                op,
    input  logic [CH_W-1:0]           op_ch,
    input  logic [WORDS*WORD_W-1:0]   hash_in,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic [WORDS*WORD_W-1:0]   hash_out
);

    localparam int HW = WORDS * WORD_W;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(WORDS - 1);
    localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(CHANNELS);

    localparam logic [1:0] OP_INIT  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ACCUM = 2'b10;

    typedef enum logic {S_IDLE, S_ACC} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [KW-1:0]      k_q, k_d;
    logic [HW-1:0]      state_q [CHANNELS];
    logic [HW-1:0]      opnd_q, opnd_d;
    logic [CH_W-1:0]    opch_q, opch_d;
    logic               out_valid_q;
    logic [CH_W-1:0]    out_ch_q;
    logic [HW-1:0]      hash_out_q;

    logic               accept;
    logic               ch_ok;
    logic               start_acc;
    logic               wr_en;
    logic [CH_W-1:0]    wr_ch;
    logic [HW-1:0]      wr_data;
    logic               done;
    logic [HW-1:0]      cur_state;
    logic [HW-1:0]      acc_state;

    // Handshake: an operation transfers on a rising edge with op_valid && op_ready;
    // op_ready depends only on the FSM state, so no input reaches an output combinationally.
    assign accept = op_valid && op_ready;
    assign ch_ok  = ({1'b0, op_ch} < CH_LIM);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q <= S_IDLE;
            k_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            k_q   <= k_d;
        end
    end

    // FSM: next state
    always_comb begin
        fsm_d = fsm_q;
        k_d   = k_q;
        case (fsm_q)
            S_IDLE: begin
                k_d = '0;
                if (start_acc) fsm_d = S_ACC;
            end
            S_ACC: begin
                if (k_q == K_LAST) begin
                    fsm_d = S_IDLE;
                    k_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                k_d   = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        op_ready = (fsm_q == S_IDLE);
    end

    // Datapath: one word of the captured channel is summed per ACC cycle, written back in place
    always_comb begin
        wr_en     = 1'b0;
        wr_ch     = op_ch;
        wr_data   = IV;
        done      = 1'b0;
        start_acc = 1'b0;
        opnd_d    = opnd_q;
        opch_d    = opch_q;
        cur_state = state_q[opch_q];
        acc_state = cur_state;
        acc_state[int'(k_q)*WORD_W +: WORD_W] =
            cur_state[int'(k_q)*WORD_W +: WORD_W] + opnd_q[int'(k_q)*WORD_W +: WORD_W];
        if (fsm_q == S_IDLE) begin
            if (accept && ch_ok) begin
                case (op)
                    OP_INIT: begin
                        wr_en = 1'b1;
                        done  = 1'b1;
                    end
                    OP_LOAD: begin
                        wr_en   = 1'b1;
                        wr_data = hash_in;
                        done    = 1'b1;
                    end
                    OP_ACCUM: begin
                        start_acc = 1'b1;
                        opnd_d    = hash_in;
                        opch_d    = op_ch;
                    end
                    default: ;
                endcase
            end
        end else begin
            wr_en   = 1'b1;
            wr_ch   = opch_q;
            wr_data = acc_state;
            done    = (k_q == K_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) state_q[c] <= IV;
            opnd_q      <= '0;
            opch_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            hash_out_q  <= IV;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_en && (wr_ch == CH_W'(c))) state_q[c] <= wr_data;
            end
            opnd_q      <= opnd_d;
            opch_q      <= opch_d;
            out_valid_q <= done;
            if (done) begin
                out_ch_q   <= wr_ch;
                hash_out_q <= wr_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign hash_out  = hash_out_q;

endmodule

// File: tb/tb_hash_state_bank.sv
// Bench for hash_state_bank: directed vector table, multi-cycle corner sequences and
// random operations against a word-array model of the channel states.
module tb_hash_state_bank;

    localparam int W    = 32;
    localparam int N    = 8;
    localparam int CH_W = 2;
    localparam int HW   = W * N;

    localparam logic [1:0] OP_INIT  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ACCUM = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [HW-1:0] IV_C = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [HW-1:0] IV_P1 = {
        32'h6a09e668, 32'hbb67ae86, 32'h3c6ef373, 32'ha54ff53b,
        32'h510e5280, 32'h9b05688d, 32'h1f83d9ac, 32'h5be0cd1a};
    localparam logic [HW-1:0] ONES = {8{32'h00000001}};
    localparam logic [HW-1:0] TWOS = {8{32'h00000002}};
    localparam logic [HW-1:0] FFS  = {8{32'hffffffff}};
    localparam logic [HW-1:0] MSB  = {8{32'h80000000}};

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [1:0]      op = 2'b00;
    logic [CH_W-1:0] op_ch = '0;
    logic [HW-1:0]   hash_in = '0;
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    logic [HW-1:0]   hash_out;

    logic            b_valid = 1'b0;
    logic            b_ready;
    logic [1:0]      b_op = 2'b00;
    logic [CH_W-1:0] b_ch = '0;
    logic [HW-1:0]   b_hash = '0;
    logic            b_out_valid;
    logic [CH_W-1:0] b_out_ch;
    logic [HW-1:0]   b_hash_out;

    hash_state_bank dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .op_ch(op_ch), .hash_in(hash_in), .out_valid(out_valid),
        .out_ch(out_ch), .hash_out(hash_out));

    hash_state_bank #(.CHANNELS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .op_valid(b_valid), .op_ready(b_ready),
        .op(b_op), .op_ch(b_ch), .hash_in(b_hash), .out_valid(b_out_valid),
        .out_ch(b_out_ch), .hash_out(b_hash_out));

    int checks = 0;
    int errors = 0;

    // reference model: word 0 is the most significant slice
    logic [W-1:0]    m_st [4][N];
    logic [HW-1:0]   exp_q[$];
    logic [CH_W-1:0] exp_ch_q[$];

    task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word_of(input logic [HW-1:0] v, input int w);
        return v[(N-1-w)*W +: W];
    endfunction

    function automatic logic [HW-1:0] model_pack(input int c);
        logic [HW-1:0] p;
        for (int w = 0; w < N; w++) p[(N-1-w)*W +: W] = m_st[c][w];
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < N; w++) m_st[c][w] = word_of(IV_C, w);
    endtask

    task automatic model_apply(input logic [1:0] o, input int c, input logic [HW-1:0] h);
        for (int w = 0; w < N; w++) begin
            case (o)
                OP_INIT:  m_st[c][w] = word_of(IV_C, w);
                OP_LOAD:  m_st[c][w] = word_of(h, w);
                OP_ACCUM: m_st[c][w] = m_st[c][w] + word_of(h, w);
                default: ;
            endcase
        end
    endtask

    function automatic logic [HW-1:0] rand_hash();
        logic [HW-1:0] r;
        for (int w = 0; w < N; w++) r[w*W +: W] = $urandom;
        return r;
    endfunction

    // scoreboard: every completion must match the oldest expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid act=1 exp=0 out_ch=%0d", out_ch);
            end else begin
                chk("hash_out", hash_out, exp_q.pop_front());
                chk("out_ch", HW'(out_ch), HW'(exp_ch_q.pop_front()));
            end
        end
    end

    // driver: issue one op, wait for its completion, check latency and busy window
    task automatic issue(input logic [1:0] o, input logic [CH_W-1:0] c, input logic [HW-1:0] h);
        int n;
        int busy;
        bit completes;
        completes = (o != OP_RSVD);
        if (completes) begin
            model_apply(o, int'(c), h);
            exp_q.push_back(model_pack(int'(c)));
            exp_ch_q.push_back(c);
        end
        @(negedge clk);
        op_valid = 1'b1; op = o; op_ch = c; hash_in = h;
        n = 0;
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", HW'(op_ready), HW'(1));
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = 2'($urandom); op_ch = 2'($urandom); hash_in = rand_hash();
        n = 0;
        busy = 0;
        do begin
            @(negedge clk);
            n++;
            if (!op_ready) busy++;
        end while (!(completes && out_valid === 1'b1) && n < (completes ? 20 : 3));
        if (completes) chk("latency", HW'(n), HW'((o == OP_ACCUM) ? N + 1 : 1));
        chk("busy_cycles", HW'(busy), HW'((o == OP_ACCUM && completes) ? N : 0));
    endtask

    task automatic b_run(input logic [1:0] o, input logic [CH_W-1:0] c,
                         input logic [HW-1:0] h, output int n);
        @(negedge clk);
        chk("b_ready", HW'(b_ready), HW'(1));
        b_valid = 1'b1; b_op = o; b_ch = c; b_hash = h;
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_hash = rand_hash();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b_out_valid !== 1'b1 && n < 12);
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [CH_W-1:0] ch;
        logic [HW-1:0]   hin;
        logic [HW-1:0]   exp;
    } vec_t;

    vec_t vt [10];

    initial begin
        int n;
        logic [HW-1:0] ha, hb, p;

        vt[0] = '{OP_ACCUM, 2'd0, '0,   IV_C};
        vt[1] = '{OP_ACCUM, 2'd1, '0,   IV_C};
        vt[2] = '{OP_ACCUM, 2'd2, '0,   IV_C};
        vt[3] = '{OP_ACCUM, 2'd3, '0,   IV_C};
        vt[4] = '{OP_ACCUM, 2'd1, ONES, IV_P1};
        vt[5] = '{OP_LOAD,  2'd2, FFS,  FFS};
        vt[6] = '{OP_ACCUM, 2'd2, TWOS, ONES};
        vt[7] = '{OP_LOAD,  2'd3, MSB,  MSB};
        vt[8] = '{OP_ACCUM, 2'd3, MSB,  '0};
        vt[9] = '{OP_INIT,  2'd3, FFS,  IV_C};

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", HW'(op_ready), HW'(1));
        chk("rst_out_valid", HW'(out_valid), HW'(0));
        chk("rst_out_ch", HW'(out_ch), HW'(0));
        chk("rst_hash_out", hash_out, IV_C);
        reset_n = 1'b1;

        // asynchronous reset pulse in the middle of a cycle
        issue(OP_LOAD, 2'd0, rand_hash());
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_ready", HW'(op_ready), HW'(1));
        chk("async_rst_valid", HW'(out_valid), HW'(0));
        chk("async_rst_hash", hash_out, IV_C);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].op, vt[i].ch, vt[i].hin);
            chk($sformatf("vec%0d", i), hash_out, vt[i].exp);
        end
        for (int c = 0; c < 4; c++) issue(OP_ACCUM, CH_W'(c), '0);

        // held request during ACC: result uses captured operands, held op taken on out_valid cycle
        ha = rand_hash();
        hb = rand_hash();
        model_apply(OP_ACCUM, 0, ha);
        exp_q.push_back(model_pack(0));
        exp_ch_q.push_back(2'd0);
        model_apply(OP_LOAD, 2, hb);
        exp_q.push_back(model_pack(2));
        exp_ch_q.push_back(2'd2);
        @(negedge clk);
        op_valid = 1'b1; op = OP_ACCUM; op_ch = 2'd0; hash_in = ha;
        @(posedge clk);
        #1;
        op = OP_LOAD; op_ch = 2'd2; hash_in = hb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 20);
        chk("held_latency", HW'(n), HW'(N + 1));
        chk("held_ready", HW'(op_ready), HW'(1));
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("held_accept", HW'(out_valid), HW'(1));

        // reset during an accumulate on ch3 at k=4
        @(negedge clk);
        op_valid = 1'b1; op = OP_ACCUM; op_ch = 2'd3; hash_in = FFS;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midacc_ready", HW'(op_ready), HW'(1));
        chk("midacc_valid", HW'(out_valid), HW'(0));
        chk("midacc_hash", hash_out, IV_C);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        exp_q.delete();
        exp_ch_q.delete();
        repeat (10) @(negedge clk);
        issue(OP_LOAD, 2'd1, rand_hash());
        issue(OP_ACCUM, 2'd3, '0);
        chk("midacc_ch3_iv", hash_out, IV_C);

        // random mix against the model
        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), CH_W'($urandom_range(0, 3)), rand_hash());
        for (int c = 0; c < 4; c++) issue(OP_ACCUM, CH_W'(c), '0);

        // three-channel instance: reserved op and out-of-range channel are no-ops
        p = rand_hash();
        b_run(OP_LOAD, 2'd0, p, n);
        chk("b_load_lat", HW'(n), HW'(1));
        chk("b_load_hash", b_hash_out, p);
        b_run(OP_RSVD, 2'd1, rand_hash(), n);
        chk("b_rsvd_no_valid", HW'(n), HW'(12));
        b_run(OP_ACCUM, 2'd3, rand_hash(), n);
        chk("b_badch_no_valid", HW'(n), HW'(12));
        b_run(OP_LOAD, 2'd3, rand_hash(), n);
        chk("b_badch_load_no_valid", HW'(n), HW'(12));
        b_run(OP_ACCUM, 2'd0, '0, n);
        chk("b_read0_lat", HW'(n), HW'(N + 1));
        chk("b_read0_hash", b_hash_out, p);
        chk("b_read0_ch", HW'(b_out_ch), HW'(0));
        b_run(OP_ACCUM, 2'd1, '0, n);
        chk("b_read1_hash", b_hash_out, IV_C);
        b_run(OP_ACCUM, 2'd2, '0, n);
        chk("b_read2_hash", b_hash_out, IV_C);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", HW'(exp_q.size()), HW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
